// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, instruction field positions and FSM state type for the ALU issue controller.
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_PAS = 3'd5;
  localparam logic [2:0] OP_BEQ = 3'd6;
  localparam logic [2:0] OP_BNE = 3'd7;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RS1_MSB = 10;
  localparam int RS1_LSB = 9;
  localparam int RS2_MSB = 8;
  localparam int RS2_LSB = 7;
  localparam int OFF_MSB = 6;
  localparam int OFF_LSB = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WB} state_t;
  function automatic logic is_branch(input logic [2:0] op);
    return op[2] & op[1];
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 4x8 register file with two async read ports, a debug read port and one sync write port.
module alu_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_we,
  input  logic [1:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [1:0] i_raddr_a,
  input  logic [1:0] i_raddr_b,
  input  logic [1:0] i_dbg_addr,
  output logic [7:0] o_rdata_a,
  output logic [7:0] o_rdata_b,
  output logic [7:0] o_dbg_data
);
  logic [7:0] r_mem [4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end
  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: three-phase (accept, issue, write-back) controller driving an external ALU
// from a small register file, with branch-capable program counter and sticky add overflow.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr_data,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [2:0]      alu_sel,
  input  logic [7:0]      alu_f,
  input  logic            alu_ovf,
  input  logic            alu_take_branch,
  input  logic            init_we,
  input  logic [1:0]      init_addr,
  input  logic [7:0]      init_data,
  input  logic [1:0]      dbg_addr,
  output logic [7:0]      dbg_data,
  output logic [PC_W-1:0] pc,
  output logic            ovf_sticky,
  output logic            busy
);
  state_t          r_state;
  logic [15:0]     r_instr;
  logic [7:0]      r_f;
  logic            r_ovf;
  logic            r_take;
  logic [PC_W-1:0] r_pc;
  logic            r_sticky;
  logic [2:0]      w_op;
  logic [1:0]      w_rd;
  logic [1:0]      w_rs1;
  logic [1:0]      w_rs2;
  logic [6:0]      w_off;
  logic [7:0]      w_rd_a;
  logic [7:0]      w_rd_b;
  logic            w_we;
  logic [1:0]      w_waddr;
  logic [7:0]      w_wdata;
  logic            w_issue;
  logic [PC_W-1:0] w_pc_step;
  assign w_op    = r_instr[OP_MSB:OP_LSB];
  assign w_rd    = r_instr[RD_MSB:RD_LSB];
  assign w_rs1   = r_instr[RS1_MSB:RS1_LSB];
  assign w_rs2   = r_instr[RS2_MSB:RS2_LSB];
  assign w_off   = r_instr[OFF_MSB:OFF_LSB];
  assign w_issue = r_state == ST_ISSUE;
  assign instr_ready = (r_state == ST_IDLE) & ~init_we;
  assign busy        = r_state != ST_IDLE;
  assign pc          = r_pc;
  assign ovf_sticky  = r_sticky;
  assign alu_a   = w_issue ? w_rd_a : '0;
  assign alu_b   = w_issue ? w_rd_b : '0;
  assign alu_sel = w_issue ? w_op : '0;
  // Single write port: preload owns it in IDLE, result write-back owns it in WB.
  assign w_we    = (r_state == ST_IDLE) ? init_we : (r_state == ST_WB) & ~is_branch(w_op);
  assign w_waddr = (r_state == ST_IDLE) ? init_addr : w_rd;
  assign w_wdata = (r_state == ST_IDLE) ? init_data : r_f;
  assign w_pc_step = (is_branch(w_op) & r_take) ? {{(PC_W-7){w_off[6]}}, w_off} : PC_W'(1);
  alu_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_raddr_a  (w_rs1),
    .i_raddr_b  (w_rs2),
    .i_dbg_addr (dbg_addr),
    .o_rdata_a  (w_rd_a),
    .o_rdata_b  (w_rd_b),
    .o_dbg_data (dbg_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_instr  <= '0;
      r_f      <= '0;
      r_ovf    <= 1'b0;
      r_take   <= 1'b0;
      r_pc     <= '0;
      r_sticky <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (instr_valid & instr_ready) begin
            r_instr <= instr_data;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_f     <= alu_f;
          r_ovf   <= alu_ovf;
          r_take  <= alu_take_branch;
          r_state <= ST_WB;
        end
        ST_WB: begin
          r_pc    <= r_pc + w_pc_step;
          if ((w_op == OP_ADD) & r_ovf) r_sticky <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
